// File: rtl/snow64_iter_int_vector_caster_pkg.sv
// Shared caster types: integer size encoding, iterative caster port bundles and FSM states.
// The vector payload is parameter-sized, so it travels beside these bundles rather than inside them.
package PkgSnow64Caster;

  localparam int WIDTH__INT_TYPE_SIZE = 2;

  localparam logic [WIDTH__INT_TYPE_SIZE-1:0] IntTypSz8  = 2'd0;
  localparam logic [WIDTH__INT_TYPE_SIZE-1:0] IntTypSz16 = 2'd1;
  localparam logic [WIDTH__INT_TYPE_SIZE-1:0] IntTypSz32 = 2'd2;
  localparam logic [WIDTH__INT_TYPE_SIZE-1:0] IntTypSz64 = 2'd3;

  typedef struct packed {
    logic                            start;
    logic                            type_signedness;
    logic                            saturate;
    logic [WIDTH__INT_TYPE_SIZE-1:0] src_int_type_size;
    logic [WIDTH__INT_TYPE_SIZE-1:0] dst_int_type_size;
  } PortIn_IterIntVectorCaster;

  typedef struct packed {
    logic busy;
    logic valid;
  } PortOut_IterIntVectorCaster;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } IterCasterState;

  function automatic int int_type_bits(input logic [WIDTH__INT_TYPE_SIZE-1:0] sz);
    return 8 << sz;
  endfunction

endpackage

// File: rtl/snow64_int_element_caster.sv
// Combinational cast of one integer element (8..64 bits) to another integer size.
// Only the low dst-size bits of o_result are meaningful; the caller masks the rest.
module snow64_int_element_caster
  import PkgSnow64Caster::*;
(
  input  logic [63:0]                     i_elem,
  input  logic                            i_signed,
  input  logic                            i_saturate,
  input  logic [WIDTH__INT_TYPE_SIZE-1:0] i_src_size,
  input  logic [WIDTH__INT_TYPE_SIZE-1:0] i_dst_size,
  output logic [63:0]                     o_result
);

  // One extra bit keeps a full-width unsigned source non-negative in signed compares.
  logic signed [64:0] w_ext;
  logic signed [64:0] w_max;
  logic signed [64:0] w_min;

  always_comb begin
    w_ext = '0;
    case (i_src_size)
      IntTypSz8:  w_ext = {{57{i_signed & i_elem[7]}},  i_elem[7:0]};
      IntTypSz16: w_ext = {{49{i_signed & i_elem[15]}}, i_elem[15:0]};
      IntTypSz32: w_ext = {{33{i_signed & i_elem[31]}}, i_elem[31:0]};
      default:    w_ext = {i_signed & i_elem[63], i_elem};
    endcase
  end

  always_comb begin
    w_max = '0;
    w_min = '0;
    case (i_dst_size)
      IntTypSz8: begin
        w_max = i_signed ? 65'sh7F : 65'shFF;
        w_min = i_signed ? -65'sh80 : 65'sh0;
      end
      IntTypSz16: begin
        w_max = i_signed ? 65'sh7FFF : 65'shFFFF;
        w_min = i_signed ? -65'sh8000 : 65'sh0;
      end
      IntTypSz32: begin
        w_max = i_signed ? 65'sh7FFF_FFFF : 65'shFFFF_FFFF;
        w_min = i_signed ? -65'sh8000_0000 : 65'sh0;
      end
      default: begin
        w_max = i_signed ? 65'sh7FFF_FFFF_FFFF_FFFF : 65'shFFFF_FFFF_FFFF_FFFF;
        w_min = i_signed ? -65'sh8000_0000_0000_0000 : 65'sh0;
      end
    endcase
  end

  always_comb begin
    o_result = w_ext[63:0];
    if (i_saturate && (i_dst_size < i_src_size)) begin
      if (w_ext > w_max) begin
        o_result = w_max[63:0];
      end else if (w_ext < w_min) begin
        o_result = w_min[63:0];
      end
    end
  end

endmodule

// File: rtl/snow64_iter_int_vector_caster.sv
// Iterative integer vector caster: one CHUNK_WIDTH output chunk per cycle after an accepted start.
// out_valid pulses the cycle the FSM returns to IDLE; a start in that cycle is accepted.
module snow64_iter_int_vector_caster
  import PkgSnow64Caster::*;
#(
  parameter int DATA_WIDTH  = 256,
  parameter int CHUNK_WIDTH = 64
)
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_start,
  input  logic [DATA_WIDTH-1:0]           in_to_cast,
  input  logic                            in_type_signedness,
  input  logic                            in_saturate,
  input  logic [WIDTH__INT_TYPE_SIZE-1:0] in_src_int_type_size,
  input  logic [WIDTH__INT_TYPE_SIZE-1:0] in_dst_int_type_size,
  output logic                            out_busy,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data
);

  localparam int N_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int N_LANES  = CHUNK_WIDTH / 8;
  localparam int CTR_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [CTR_W-1:0] LAST_CHUNK = CTR_W'(N_CHUNKS - 1);

  PortIn_IterIntVectorCaster  w_in;
  PortOut_IterIntVectorCaster w_out;

  IterCasterState r_state;
  IterCasterState w_state_nxt;
  logic           w_accept;
  logic           w_last;

  logic                            r_signed;
  logic                            r_saturate;
  logic [WIDTH__INT_TYPE_SIZE-1:0] r_src_size;
  logic [WIDTH__INT_TYPE_SIZE-1:0] r_dst_size;
  logic [DATA_WIDTH-1:0]           r_src;
  logic [DATA_WIDTH-1:0]           r_data;
  logic [CTR_W-1:0]                r_ctr;
  logic                            r_valid;

  int                     w_src_bits;
  int                     w_dst_bits;
  logic [63:0]            w_dst_mask;
  logic [63:0]            w_lane_src [N_LANES];
  logic                   w_lane_ok  [N_LANES];
  logic [63:0]            w_lane_res [N_LANES];
  logic [CHUNK_WIDTH-1:0] w_chunk;

  assign w_in = '{
    start:             in_start,
    type_signedness:   in_type_signedness,
    saturate:          in_saturate,
    src_int_type_size: in_src_int_type_size,
    dst_int_type_size: in_dst_int_type_size
  };

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_in.start) begin
          w_accept    = 1'b1;
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        w_last = (r_ctr == LAST_CHUNK);
        if (w_last) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_signed   <= 1'b0;
      r_saturate <= 1'b0;
      r_src_size <= '0;
      r_dst_size <= '0;
      r_src      <= '0;
      r_data     <= '0;
      r_ctr      <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= w_last;
      if (w_accept) begin
        r_signed   <= w_in.type_signedness;
        r_saturate <= w_in.saturate;
        r_src_size <= w_in.src_int_type_size;
        r_dst_size <= w_in.dst_int_type_size;
        r_src      <= in_to_cast;
        r_ctr      <= '0;
      end else if (r_state == StRun) begin
        r_data[r_ctr*CHUNK_WIDTH +: CHUNK_WIDTH] <= w_chunk;
        r_ctr <= r_ctr + 1'b1;
      end
    end
  end

  assign w_src_bits = int_type_bits(r_src_size);
  assign w_dst_bits = int_type_bits(r_dst_size);
  assign w_dst_mask = (r_dst_size == IntTypSz64) ? '1 : ((64'd1 << w_dst_bits) - 64'd1);

  // Lane j carries destination element (ctr * elements-per-chunk + j); lanes past the
  // chunk's element count, or whose source element lies beyond the vector, yield zero.
  always_comb begin
    int elem;
    elem = 0;
    for (int j = 0; j < N_LANES; j++) begin
      elem          = int'(r_ctr) * (CHUNK_WIDTH / w_dst_bits) + j;
      w_lane_ok[j]  = ((j * w_dst_bits) < CHUNK_WIDTH) && ((elem * w_src_bits) < DATA_WIDTH);
      w_lane_src[j] = 64'(r_src >> (elem * w_src_bits));
    end
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    snow64_int_element_caster u_elem (
      .i_elem     (w_lane_src[g]),
      .i_signed   (r_signed),
      .i_saturate (r_saturate),
      .i_src_size (r_src_size),
      .i_dst_size (r_dst_size),
      .o_result   (w_lane_res[g])
    );
  end

  always_comb begin
    w_chunk = '0;
    for (int j = 0; j < N_LANES; j++) begin
      if (w_lane_ok[j]) begin
        w_chunk = w_chunk | (CHUNK_WIDTH'(w_lane_res[j] & w_dst_mask) << (j * w_dst_bits));
      end
    end
  end

  assign w_out.busy  = (r_state == StRun);
  assign w_out.valid = r_valid;

  assign out_busy  = w_out.busy;
  assign out_valid = w_out.valid;
  assign out_data  = r_data;

endmodule

// File: tb/tb_snow64_iter_int_vector_caster.sv
// Self-checking bench: directed corner casts, handshake timing, reset abort and random casts vs an integer model.
module tb_snow64_iter_int_vector_caster;

  localparam int DW = 256;

  logic          clk;
  logic          rst_n;
  logic          in_start;
  logic [DW-1:0] in_to_cast;
  logic          in_type_signedness;
  logic          in_saturate;
  logic [1:0]    in_src_int_type_size;
  logic [1:0]    in_dst_int_type_size;
  logic          out_busy;
  logic          out_valid;
  logic [DW-1:0] out_data;

  int n_checks = 0;
  int n_errors = 0;

  snow64_iter_int_vector_caster #(.DATA_WIDTH(DW), .CHUNK_WIDTH(64)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_start             (in_start),
    .in_to_cast           (in_to_cast),
    .in_type_signedness   (in_type_signedness),
    .in_saturate          (in_saturate),
    .in_src_int_type_size (in_src_int_type_size),
    .in_dst_int_type_size (in_dst_int_type_size),
    .out_busy             (out_busy),
    .out_valid            (out_valid),
    .out_data             (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Integer-value model: decode each source element as a number, clamp if asked, keep low d bits.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] src, input logic sgn, input logic sat,
                                          input logic [1:0] ss, input logic [1:0] ds);
    int s;
    int d;
    logic [DW-1:0] r;
    s = 8 << ss;
    d = 8 << ds;
    r = '0;
    for (int i = 0; i < DW / d; i++) begin
      logic signed [127:0] v;
      logic signed [127:0] hi;
      logic signed [127:0] lo;
      logic [DW-1:0] sh;
      if (i < DW / s) begin
        sh = src >> (i * s);
        v = '0;
        for (int b = 0; b < s; b++) v[b] = sh[b];
        if (sgn && sh[s-1]) v = v - (128'sd1 <<< s);
        if (sat && (d < s)) begin
          hi = sgn ? (128'sd1 <<< (d - 1)) - 128'sd1 : (128'sd1 <<< d) - 128'sd1;
          lo = sgn ? -(128'sd1 <<< (d - 1)) : 128'sd0;
          if (v > hi) v = hi;
          else if (v < lo) v = lo;
        end
        for (int b = 0; b < d; b++) r[i*d + b] = v[b];
      end
    end
    return r;
  endfunction

  task automatic drive(input logic [DW-1:0] src, input logic sgn, input logic sat,
                       input logic [1:0] ss, input logic [1:0] ds);
    in_to_cast           = src;
    in_type_signedness   = sgn;
    in_saturate          = sat;
    in_src_int_type_size = ss;
    in_dst_int_type_size = ds;
  endtask

  // Watches n cycles after the current point; reports the first valid cycle (-1 if none) and count.
  task automatic watch(input int n, output int first, output int cnt);
    first = -1;
    cnt   = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
  endtask

  task automatic run_cast(input string tag, input logic [DW-1:0] src, input logic sgn, input logic sat,
                          input logic [1:0] ss, input logic [1:0] ds, output logic [DW-1:0] res);
    int first;
    int cnt;
    @(negedge clk);
    drive(src, sgn, sat, ss, ds);
    in_start = 1'b1;
    @(posedge clk); #1;
    in_start = 1'b0;
    check({tag, "_busy"}, DW'(out_busy), DW'(1));
    watch(8, first, cnt);
    check({tag, "_vcyc"}, DW'(first), DW'(4));
    check({tag, "_vcnt"}, DW'(cnt), DW'(1));
    res = out_data;
    check({tag, "_model"}, res, model(src, sgn, sat, ss, ds));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] res;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp;
    int first;
    int cnt;

    rst_n    = 1'b0;
    in_start = 1'b0;
    drive('0, 1'b0, 1'b0, 2'd0, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", DW'(out_busy), DW'(0));
    check("rst_valid", DW'(out_valid), DW'(0));
    check("rst_data", out_data, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // u8 -> u16 widen, unsigned then signed
    a = {32{8'h80}};
    run_cast("u8u16", a, 1'b0, 1'b0, 2'd0, 2'd1, res);
    exp = {16{16'h0080}};
    check("u8u16_const", res, exp);
    run_cast("s8s16", a, 1'b1, 1'b0, 2'd0, 2'd1, res);
    exp = {16{16'hFF80}};
    check("s8s16_const", res, exp);

    // s32 -> s8 narrow, saturating and truncating
    a = '0;
    a[31:0]  = 32'h0000_0200;
    a[63:32] = 32'hFFFF_FE00;
    run_cast("s32s8_sat", a, 1'b1, 1'b1, 2'd2, 2'd0, res);
    check("s32s8_sat_lo", DW'(res[15:0]), DW'(16'h807F));
    check("s32s8_sat_hi", DW'(res[255:64]), '0);
    run_cast("s32s8_trunc", a, 1'b1, 1'b0, 2'd2, 2'd0, res);
    check("s32s8_trunc_all", res, '0);

    // u64 -> u8 saturate
    a = '0;
    a[63:0]   = 64'h0000_0000_0000_0100;
    a[127:64] = 64'h0000_0000_0000_0005;
    run_cast("u64u8_sat", a, 1'b0, 1'b1, 2'd3, 2'd0, res);
    check("u64u8_sat_const", res, DW'(16'h05FF));

    // 32 -> 32 copy, then a start in the valid cycle
    a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    drive(a, 1'b0, 1'b0, 2'd2, 2'd2);
    in_start = 1'b1;
    @(posedge clk); #1;
    in_start = 1'b0;
    first = -1;
    for (int k = 1; k <= 8 && first < 0; k++) begin
      @(posedge clk); #1;
      if (out_valid) first = k;
    end
    check("copy_vcyc", DW'(first), DW'(4));
    check("copy_data", out_data, a);
    drive(b, 1'b1, 1'b1, 2'd1, 2'd0);
    in_start = 1'b1;
    @(posedge clk); #1;
    in_start = 1'b0;
    check("b2b_accept_busy", DW'(out_busy), DW'(1));
    check("b2b_hold_data", out_data, a);
    watch(8, first, cnt);
    check("b2b_vcyc", DW'(first), DW'(4));
    check("b2b_vcnt", DW'(cnt), DW'(1));
    check("b2b_data", out_data, model(b, 1'b1, 1'b1, 2'd1, 2'd0));

    // start pulsed mid-run with other operands must be ignored
    a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b = ~a;
    @(negedge clk);
    drive(a, 1'b0, 1'b0, 2'd1, 2'd2);
    in_start = 1'b1;
    @(posedge clk); #1;
    in_start = 1'b0;
    watch(2, first, cnt);
    check("ign_early_v", DW'(cnt), DW'(0));
    drive(b, 1'b1, 1'b1, 2'd0, 2'd3);
    in_start = 1'b1;
    @(posedge clk); #1;
    in_start = 1'b0;
    watch(8, first, cnt);
    check("ign_vcyc", DW'(first), DW'(1));
    check("ign_vcnt", DW'(cnt), DW'(1));
    check("ign_data", out_data, model(a, 1'b0, 1'b0, 2'd1, 2'd2));

    // reset in cycle 2 of a run
    @(negedge clk);
    drive(a, 1'b1, 1'b0, 2'd0, 2'd3);
    in_start = 1'b1;
    @(posedge clk); #1;
    in_start = 1'b0;
    watch(2, first, cnt);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", DW'(out_busy), DW'(0));
    check("mrst_valid", DW'(out_valid), DW'(0));
    check("mrst_data", out_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    watch(8, first, cnt);
    check("mrst_no_valid", DW'(cnt), DW'(0));
    run_cast("post_rst", a, 1'b1, 1'b0, 2'd0, 2'd3, res);

    // random casts against the model
    for (int t = 0; t < 24; t++) begin
      a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_cast($sformatf("rnd%0d", t), a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), res);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
